operand_sequencer: RTL and testbench

Byte-serial front end for the eight-bit three-operand op adder (`eight_bit_adder_op`), which sits directly downstream of this block. It accepts a command byte and three operand bytes over a valid/ready stream and holds them as stable adder inputs. It then captures the adder's combinational result and carry into registers and offers them on a valid/ready result port. A transaction counter records completed transactions.

---
 rtl/seq_pkg.sv | 19 +
 rtl/operand_sequencer.sv | 85 ++++++++
 tb/tb_operand_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the operand sequencer: FSM state encoding and the
// op-select encodings understood by the downstream three-operand adder.
package seq_pkg;

   typedef enum logic [2:0] {
      CMD  = 3'd0,
      LD_A = 3'd1,
      LD_B = 3'd2,
      LD_C = 3'd3,
      EXEC = 3'd4,
      DONE = 3'd5
   } seq_state_t;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_NEG_A = 2'b01;
   localparam logic [1:0] OP_NEG_B = 2'b10;
   localparam logic [1:0] OP_NEG_C = 2'b11;

endpackage

// File: rtl/operand_sequencer.sv
// Byte-serial front end for the three-operand adder: collects command + a/b/c
// over a valid/ready stream, captures the adder result, and offers it downstream.
module operand_sequencer
   import seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic [W-1:0] c,
   output logic [1:0]   op,
   input  logic [W-1:0] sum,
   input  logic         sum_carry,
   output logic [W-1:0] res,
   output logic         res_carry,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [7:0]   tx_count
);

   // Handshake: a beat (or a result) transfers on a rising edge where the
   // producer's valid and the consumer's ready are both 1; nothing else moves data.

   seq_state_t state, state_next;
   logic       beat;

   assign beat = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= CMD;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         CMD:     if (beat) state_next = LD_A;
         LD_A:    if (beat) state_next = LD_B;
         LD_B:    if (beat) state_next = LD_C;
         LD_C:    if (beat) state_next = EXEC;
         EXEC:    state_next = DONE;
         DONE:    if (res_ready) state_next = CMD;
         default: state_next = CMD;
      endcase
   end

   // in_ready is forced low during reset so no beat can be taken on the reset edge.
   always_comb begin
      in_ready  = 1'b0;
      res_valid = 1'b0;
      case (state)
         CMD, LD_A, LD_B, LD_C: in_ready = !rst;
         DONE:                  res_valid = 1'b1;
         default:               ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op        <= '0;
         a         <= '0;
         b         <= '0;
         c         <= '0;
         res       <= '0;
         res_carry <= 1'b0;
         tx_count  <= '0;
      end else begin
         if (beat && state == CMD)  op <= in_data[1:0];
         if (beat && state == LD_A) a  <= in_data;
         if (beat && state == LD_B) b  <= in_data;
         if (beat && state == LD_C) c  <= in_data;
         if (state == EXEC) begin
            res       <= sum;
            res_carry <= sum_carry;
         end
         if (state == DONE && res_ready) tx_count <= tx_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a behavioural stub of the
// three-operand adder driving sum/sum_carry.
module tb_operand_sequencer;
   import seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b, c;
   logic [1:0] op;
   logic [7:0] sum;
   logic       sum_carry;
   logic [7:0] res;
   logic       res_carry;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] tx_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [7:0] exp_tx = 8'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   operand_sequencer #(.W(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .op(op), .sum(sum), .sum_carry(sum_carry),
      .res(res), .res_carry(res_carry), .res_valid(res_valid), .res_ready(res_ready),
      .tx_count(tx_count)
   );

   function automatic logic [8:0] adder_model(input logic [1:0] o, input logic [7:0] x, y, z);
      logic [7:0] xa, ya, za;
      xa = (o == OP_NEG_A) ? 8'(-x) : x;
      ya = (o == OP_NEG_B) ? 8'(-y) : y;
      za = (o == OP_NEG_C) ? 8'(-z) : z;
      return 9'({1'b0, xa} + {1'b0, ya} + {1'b0, za});
   endfunction

   always_comb {sum_carry, sum} = adder_model(op, a, b, c);

   typedef struct {
      logic [7:0] cmd, av, bv, cv;
      logic [1:0] eop;
      logic [7:0] eres;
      logic       ecar;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] d, input int gap, input string tag);
      logic [25:0] snap;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_data  = ~d;
         snap = {op, a, b, c};
         step();
         check({tag, "_stall_hold"}, {6'd0, op, a, b, c}, {6'd0, snap});
      end
      in_valid = 1'b1;
      in_data  = d;
      check({tag, "_in_ready"}, in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
   endtask

   task automatic run_txn(input vec_t v, input int gap, input int hold, input string tag);
      int start;
      res_ready = (hold == 0);
      start = cyc;
      send_beat(v.cmd, gap, {tag, "_cmd"});
      check({tag, "_op"}, op, v.eop);
      send_beat(v.av, gap, {tag, "_a"});
      send_beat(v.bv, gap, {tag, "_b"});
      send_beat(v.cv, gap, {tag, "_c"});
      check({tag, "_exec_in_ready"}, in_ready, 1'b0);
      check({tag, "_exec_res_valid"}, res_valid, 1'b0);
      check({tag, "_operands"}, {6'd0, op, a, b, c}, {6'd0, v.eop, v.av, v.bv, v.cv});
      step();
      check({tag, "_res_valid"}, res_valid, 1'b1);
      check({tag, "_res"}, {res_carry, res}, {v.ecar, v.eres});
      for (int h = 0; h < hold; h++) begin
         step();
         check({tag, "_hold_res_valid"}, res_valid, 1'b1);
         check({tag, "_hold_in_ready"}, in_ready, 1'b0);
         check({tag, "_hold_res"}, {res_carry, res}, {v.ecar, v.eres});
      end
      res_ready = 1'b1;
      step();
      exp_tx = exp_tx + 8'd1;
      check({tag, "_post_res_valid"}, res_valid, 1'b0);
      check({tag, "_post_in_ready"}, in_ready, 1'b1);
      check({tag, "_tx_count"}, tx_count, exp_tx);
      if (gap == 0 && hold == 0) check({tag, "_edges"}, cyc - start, 6);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_regs"}, {6'd0, op, a, b, c}, 32'd0);
      check({tag, "_res"}, {res_carry, res}, 9'd0);
      check({tag, "_res_valid"}, res_valid, 1'b0);
      check({tag, "_tx_count"}, tx_count, 8'd0);
      check({tag, "_in_ready_in_rst"}, in_ready, 1'b0);
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{8'h00, 8'h05, 8'h03, 8'h02, 2'b00, 8'h0A, 1'b0};
      vecs[1] = '{8'hFD, 8'h01, 8'h10, 8'h00, 2'b01, 8'h0F, 1'b1};
      vecs[2] = '{8'h02, 8'h20, 8'h01, 8'h03, 2'b10, 8'h22, 1'b1};
      vecs[3] = '{8'hFF, 8'h80, 8'h80, 8'h00, 2'b11, 8'h00, 1'b1};
      vecs[4] = '{8'h00, 8'h80, 8'h7F, 8'h01, 2'b00, 8'h00, 1'b1};
      vecs[5] = '{8'h7C, 8'h01, 8'h02, 8'h03, 2'b00, 8'h06, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b1;
      step(); step(); step();
      check_reset_state("reset");
      rst = 1'b0;
      #1;
      check("reset_release_in_ready", in_ready, 1'b1);

      foreach (vecs[i]) run_txn(vecs[i], 0, 0, $sformatf("vec%0d", i));

      // Valid toggling every other cycle plus a 5-cycle result backpressure.
      v = '{8'h01, 8'h03, 8'h04, 8'h05, 2'b01, 8'h06, 1'b1};
      run_txn(v, 1, 5, "toggle");

      // Reset right after the b beat aborts the transaction.
      res_ready = 1'b1;
      send_beat(8'h00, 0, "abort_cmd");
      send_beat(8'h11, 0, "abort_a");
      send_beat(8'h22, 0, "abort_b");
      rst = 1'b1;
      #1;
      check("abort_in_ready_rst", in_ready, 1'b0);
      step();
      check_reset_state("abort");
      rst = 1'b0;
      #1;
      check("abort_in_ready_cmd", in_ready, 1'b1);
      exp_tx = 8'd0;
      v = '{8'h00, 8'h05, 8'h03, 8'h02, 2'b00, 8'h0A, 1'b0};
      run_txn(v, 0, 0, "after_abort");

      // Clear the counter, then 256 back-to-back transactions wrap it to 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      exp_tx = 8'd0;
      for (int k = 0; k < 256; k++) begin
         logic [8:0] m;
         v.cmd = {6'($urandom_range(0, 63)), 2'(k)};
         v.av  = 8'(k);
         v.bv  = 8'(k * 3);
         v.cv  = 8'(k) ^ 8'h5A;
         v.eop = 2'(k);
         m = adder_model(v.eop, v.av, v.bv, v.cv);
         v.eres = m[7:0];
         v.ecar = m[8];
         run_txn(v, 0, 0, $sformatf("b2b%0d", k));
      end
      check("wrap_tx_count", tx_count, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
